alu_exec: RTL and testbench
===========================

# alu_exec

- Execute-stage ALU for the single-cycle CPU datapath.
- Consumes the 4-bit ALU control code from the ALU control decoder, plus two 32-bit operands and a shift amount.
- Produces a registered result, a zero flag and an error flag.
- Add, sub, logic and jr pass-through complete in one cycle. Shifts run iteratively, one bit per cycle, behind a valid/ready handshake.

## Interface

Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width (log2 WIDTH)

Ports:
- Clocking: one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; high only in IDLE
- alu_op  input  4  control code: 1110 add, 0100 sub, 0010 and, 0011 or, 0111 xor, 1010 sll, 1000 srl, 1001 sra, 1100 jr
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt / immediate)
- shamt  input  SHW  shift amount
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- op_err  output  1  alu_op not in the table above
- ovf  output  1  signed overflow on add/sub (see Configuration)

## Operation

- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE), driven combinationally.
- IDLE, accept on in_valid && in_ready; operands are sampled on the accept edge.
- Non-shift ops:
  - result <= op(a, b).
  - jr: result <= a.
  - add/sub: WIDTH-bit wrap-around arithmetic.
  - Next state DONE.
- Shift ops (sll/srl/sra):
  - Shift register <= b; counter <= shamt.
  - shamt == 0: go to DONE with result = b.
  - Otherwise go to SHIFT.
- SHIFT, once per cycle:
  - Shift one bit: sll fills 0, srl fills 0, sra replicates bit WIDTH-1.
  - Decrement counter; when counter reaches 0, go to DONE.
- Undefined alu_op: result <= 0, op_err <= 1, next state DONE.
- DONE:
  - out_valid = 1; result, zero, op_err and ovf are held stable.
  - On out_ready: go to IDLE and clear out_valid.
- zero, op_err and ovf are registered alongside result and update on the same edge.
- In SHIFT, result tracks the partial value; consumers must ignore it until out_valid.

## Timing

- Reset (async, immediate): state = IDLE, result = 0, zero = 1, op_err = 0, ovf = 0, out_valid = 0, counter = 0. in_ready = 1 while in reset.
- Latency, accept edge to out_valid high:
  - 1 cycle for non-shift and undefined ops.
  - 1 + shamt cycles for shifts; shamt = 31 gives 32 cycles.
- Throughput: at most one op per 2 cycles. in_ready rises in the cycle after the output handshake; no accept is possible in the same cycle.
- in_valid while busy is ignored. The requester must hold its request until in_ready.
- out_ready while out_valid = 0 has no effect.
- Reset asserted mid-SHIFT or in DONE aborts the operation; the pending result is discarded.
- alu_op, a, b and shamt changing after accept have no effect.

## Configuration

- Macro ALU_EXEC_OVF_EN.
- Defined:
  - add: ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - sub: ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
  - All other ops: ovf = 0.
  - result is still written on overflow; trap handling is decided downstream.
- Undefined: ovf is tied to 0 and the overflow logic is not compiled. The port remains present.

## Test plan

- Reset mid-SHIFT: sll with b = 1, shamt = 10; assert rst 3 cycles after accept -> out_valid = 0, result = 0, zero = 1, in_ready = 1 immediately.
- add: a = 0x0000_0005, b = 0xFFFF_FFFB -> result = 0, zero = 1, out_valid 1 cycle after accept; with out_ready held low, all outputs stay stable for 5 cycles.
- sra: b = 0x8000_0000, shamt = 4 -> result = 0xF800_0000 exactly 5 cycles after accept. srl of the same operand -> 0x0800_0000. shamt = 0 -> result = 0x8000_0000 after 1 cycle.
- Undefined alu_op 4'b0000, a = 7 -> result = 0, op_err = 1, zero = 1. A following valid and (0xF0 & 0x3C) -> 0x30, op_err = 0.
- Overflow: add 0x7FFF_FFFF + 1 -> result 0x8000_0000. With ALU_EXEC_OVF_EN defined: ovf = 1; sub 0x8000_0000 - 1 -> ovf = 1; jr a = 0x0040_0010 -> result = a, ovf = 0. Without the macro: ovf = 0 throughout.
- Handshake: in_valid held high during a 20-cycle shift -> exactly one accept; in_ready = 0 throughout; second accept occurs one cycle after the output handshake.

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle for the execute-stage ALU.
// master = requester/consumer side, slave = the ALU itself.
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             op_err;
  logic             ovf;

  modport master (
    output in_valid, alu_op, a, b, shamt,
    output out_ready,
    input  in_ready, out_valid, result,
    input  zero, op_err, ovf
  );

  modport slave (
    input  in_valid, alu_op, a, b, shamt,
    input  out_ready,
    output in_ready, out_valid, result,
    output zero, op_err, ovf
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU, one-cycle arith/logic, bit-serial shifts.
// Define ALU_EXEC_OVF_EN to enable the signed-overflow flag on add/sub.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_t;

  state_t           state;
  sh_t              sh_kind;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             err_q;
  logic             vld_q;

  logic is_add, is_sub, is_and, is_or, is_xor;
  logic is_sll, is_srl, is_sra, is_jr;

  assign is_add = (bus.alu_op == 4'b1110);
  assign is_sub = (bus.alu_op == 4'b0100);
  assign is_and = (bus.alu_op == 4'b0010);
  assign is_or  = (bus.alu_op == 4'b0011);
  assign is_xor = (bus.alu_op == 4'b0111);
  assign is_sll = (bus.alu_op == 4'b1010);
  assign is_srl = (bus.alu_op == 4'b1000);
  assign is_sra = (bus.alu_op == 4'b1001);
  assign is_jr  = (bus.alu_op == 4'b1100);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  logic [WIDTH-1:0] op_res;
  logic             op_shift;
  logic             op_bad;
  sh_t              op_kind;

  // decode the request into a one-cycle result or a shift setup
  always_comb begin
    op_res   = '0;
    op_shift = 1'b0;
    op_bad   = 1'b0;
    op_kind  = SH_LL;
    unique case (1'b1)
      is_add: op_res = sum;
      is_sub: op_res = diff;
      is_and: op_res = bus.a & bus.b;
      is_or:  op_res = bus.a | bus.b;
      is_xor: op_res = bus.a ^ bus.b;
      is_jr:  op_res = bus.a;
      is_sll: begin
        op_shift = 1'b1;
        op_kind  = SH_LL;
      end
      is_srl: begin
        op_shift = 1'b1;
        op_kind  = SH_RL;
      end
      is_sra: begin
        op_shift = 1'b1;
        op_kind  = SH_RA;
      end
      default: op_bad = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] sh_next;

  // one-bit step of the in-flight shift
  always_comb begin
    sh_next = res_q << 1;
    case (sh_kind)
      SH_RL:   sh_next = res_q >> 1;
      SH_RA:   sh_next = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      default: sh_next = res_q << 1;
    endcase
  end

  // control FSM; result doubles as the shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh_kind <= SH_LL;
      cnt     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            err_q   <= op_bad;
            sh_kind <= op_kind;
            if (op_shift) begin
              res_q  <= bus.b;
              zero_q <= (bus.b == '0);
              cnt    <= bus.shamt;
              if (bus.shamt == '0) begin
                state <= DONE;
                vld_q <= 1'b1;
              end else begin
                state <= SHIFT;
              end
            end else begin
              res_q  <= op_res;
              zero_q <= (op_res == '0);
              state  <= DONE;
              vld_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          res_q  <= sh_next;
          zero_q <= (sh_next == '0);
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state <= DONE;
            vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            vld_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_EXEC_OVF_EN
  logic op_ovf;
  logic ovf_q;

  // signed overflow: operand signs vs. result sign
  always_comb begin
    op_ovf = 1'b0;
    if (is_add) begin
      op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
               (sum[WIDTH-1] != bus.a[WIDTH-1]);
    end else if (is_sub) begin
      op_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
               (diff[WIDTH-1] != bus.a[WIDTH-1]);
    end
  end

  // overflow flag captured on the accept edge, held through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      ovf_q <= op_ovf;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.op_err    = err_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: vector table, hand sequences and random ops vs. a model.
// Overflow expectations follow ALU_EXEC_OVF_EN.
module tb_alu_exec;
  localparam int W = 32;

`ifdef ALU_EXEC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   acc_cnt;

  alu_exec_if #(.WIDTH(W), .SHW(5)) bus ();

  alu_exec #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    bit          err;
    bit          ovf;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // reference: plain arithmetic on whole words, no iteration
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] sh,
                       output logic [31:0] r,
                       output bit err,
                       output bit ov,
                       output int lat);
    longint s;
    err = 1'b0;
    ov  = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      4'b1110: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0111: r = a ^ b;
      4'b1100: r = a;
      4'b1010: begin
        r = b << sh;
        lat = 1 + int'(sh);
      end
      4'b1000: begin
        r = b >> sh;
        lat = 1 + int'(sh);
      end
      4'b1001: begin
        r = $signed(b) >>> sh;
        lat = 1 + int'(sh);
      end
      default: err = 1'b1;
    endcase
  endtask

  task automatic run_op(input string nm,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] sh,
                        input logic [31:0] er,
                        input bit ee,
                        input bit eo,
                        input int el,
                        input int hold);
    int g;
    int lat;
    bit ov;
    ov = eo && OVF_EN;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      tick();
      g++;
    end
    chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
    tick();
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.shamt    = 5'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " result"}, 64'(bus.result), 64'(er));
    chk({nm, " zero"}, 64'(bus.zero), 64'(er == 0));
    chk({nm, " op_err"}, 64'(bus.op_err), 64'(ee));
    chk({nm, " ovf"}, 64'(bus.ovf), 64'(ov));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({nm, " hold"},
          64'({bus.out_valid, bus.result, bus.zero,
               bus.op_err, bus.ovf}),
          64'({1'b1, er, er == 0, ee, ov}));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, " drained"},
        64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  vec_t vecs[14];

  function automatic vec_t mk(string nm, logic [3:0] op,
                              logic [31:0] a, logic [31:0] b,
                              logic [4:0] sh, logic [31:0] res,
                              bit err, bit ovf, int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.res = res; v.err = err; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic [4:0]  rsh;
    bit          e;
    bit          o;
    int          l;
    int          a0;
    int          g;
    bit          busy_rdy;
    logic [3:0]  codes[9];

    n_tests = 0;
    n_fail  = 0;
    acc_cnt = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.shamt     = '0;

    vecs[0]  = mk("add_zero", 4'b1110, 32'h5, 32'hFFFF_FFFB,
                  5'd0, 32'h0, 0, 0, 1);
    vecs[1]  = mk("sra4", 4'b1001, 32'h0, 32'h8000_0000,
                  5'd4, 32'hF800_0000, 0, 0, 5);
    vecs[2]  = mk("srl4", 4'b1000, 32'h0, 32'h8000_0000,
                  5'd4, 32'h0800_0000, 0, 0, 5);
    vecs[3]  = mk("sra0", 4'b1001, 32'h0, 32'h8000_0000,
                  5'd0, 32'h8000_0000, 0, 0, 1);
    vecs[4]  = mk("undef", 4'b0000, 32'h7, 32'h0,
                  5'd0, 32'h0, 1, 0, 1);
    vecs[5]  = mk("and", 4'b0010, 32'hF0, 32'h3C,
                  5'd0, 32'h30, 0, 0, 1);
    vecs[6]  = mk("add_ovf", 4'b1110, 32'h7FFF_FFFF, 32'h1,
                  5'd0, 32'h8000_0000, 0, 1, 1);
    vecs[7]  = mk("sub_ovf", 4'b0100, 32'h8000_0000, 32'h1,
                  5'd0, 32'h7FFF_FFFF, 0, 1, 1);
    vecs[8]  = mk("jr", 4'b1100, 32'h0040_0010, 32'h1234,
                  5'd0, 32'h0040_0010, 0, 0, 1);
    vecs[9]  = mk("or", 4'b0011, 32'hA0A0_0000, 32'h0000_0505,
                  5'd0, 32'hA0A0_0505, 0, 0, 1);
    vecs[10] = mk("xor", 4'b0111, 32'hFFFF_0000, 32'hFF00_FF00,
                  5'd0, 32'h00FF_FF00, 0, 0, 1);
    vecs[11] = mk("sll31", 4'b1010, 32'h0, 32'h1,
                  5'd31, 32'h8000_0000, 0, 0, 32);
    vecs[12] = mk("sra31", 4'b1001, 32'h0, 32'h8000_0001,
                  5'd31, 32'hFFFF_FFFF, 0, 0, 32);
    vecs[13] = mk("sub", 4'b0100, 32'h10, 32'h30,
                  5'd0, 32'hFFFF_FFE0, 0, 0, 1);

    tick();
    tick();
    chk("reset outs",
        64'({bus.in_ready, bus.out_valid, bus.result,
             bus.zero, bus.op_err, bus.ovf}),
        64'({1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    tick();

    // add with result held for 5 cycles
    run_op("add_hold", 4'b1110, 32'h5, 32'hFFFF_FFFB, 5'd0,
           32'h0, 0, 0, 1, 5);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].sh, vecs[i].res, vecs[i].err, vecs[i].ovf,
             vecs[i].lat, i % 3);
    end

    // reset mid-shift
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b1010;
    bus.b        = 32'h1;
    bus.shamt    = 5'd10;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst mid-shift",
        64'({bus.out_valid, bus.result, bus.zero,
             bus.in_ready, bus.op_err}),
        64'({1'b0, 32'h0, 1'b1, 1'b1, 1'b0}));
    #2;
    rst = 1'b0;
    tick();
    chk("after rst idle",
        64'({bus.out_valid, bus.in_ready}), 64'b01);

    // in_valid held through a 20-cycle shift
    a0 = acc_cnt;
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b1010;
    bus.b        = 32'h3;
    bus.shamt    = 5'd19;
    tick();
    busy_rdy = 1'b0;
    g = 1;
    while (!bus.out_valid && g < 64) begin
      if (bus.in_ready) busy_rdy = 1'b1;
      tick();
      g++;
    end
    if (bus.in_ready) busy_rdy = 1'b1;
    chk("hs latency", 64'(g), 64'd20);
    chk("hs busy ready", 64'(busy_rdy), 64'd0);
    chk("hs one accept", 64'(acc_cnt - a0), 64'd1);
    chk("hs result", 64'(bus.result), 64'(32'h3 << 19));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hs ready after out",
        64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("hs no same-cycle acc", 64'(acc_cnt - a0), 64'd1);
    tick();
    chk("hs second accept", 64'(acc_cnt - a0), 64'd2);
    chk("hs busy again", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 64) begin
      tick();
      g++;
    end
    chk("hs second done", 64'(bus.result), 64'(32'h3 << 19));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // random ops against the model
    codes = '{4'b1110, 4'b0100, 4'b0010, 4'b0011, 4'b0111,
              4'b1010, 4'b1000, 4'b1001, 4'b1100};
    for (int i = 0; i < 200; i++) begin
      l = int'($urandom_range(0, 9));
      rop = (l == 9) ? 4'($urandom) : codes[l];
      ra  = $urandom;
      rb  = (i % 7 == 0) ? ra : $urandom;
      rsh = 5'($urandom);
      model(rop, ra, rb, rsh, r, e, o, l);
      run_op("rand", rop, ra, rb, rsh, r, e, o, l,
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
